mod3187_mul_prefold: RTL
========================

Name: mod3187_mul_prefold

Overview:
- Two-stage pipelined modular-multiply front end for prime Q = 3187.
- Takes two residues and forms their 24-bit product. It then folds the product once, using 2^12 ≡ 909 (mod 3187), into a 23-bit value that is congruent to the product mod Q.
- Output drives din_a of the barret_for_3187 reducer directly; that reducer's dout_r is the final residue.
- Valid/ready handshakes on both sides allow stalls from the consumer.

Parameters:
- Q, 3187, prime modulus.
- W, 12, operand width in bits.
- FOLD, 909, constant 2^W − Q used for the single fold.
- OUT_W, 23, output width; matches the reducer's din_a.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block accepts a pair this cycle.
- a  input  W  operand A; legal range 0..Q−1.
- b  input  W  operand B; legal range 0..Q−1.
- out_valid  output  1  folded result present.
- out_ready  input  1  consumer accepts the result this cycle.
- out_data  output  OUT_W  folded value, ≡ a·b (mod Q); feeds din_a.
- out_err  output  1  the corresponding a or b was ≥ Q.

Behaviour:
- Reset (async assert, release synchronised to clk by the integrator):
  - v1, v2, out_valid = 0.
  - out_data, out_err, and all internal data registers = 0.
  - in_ready = 1 one cycle after reset release.
- Stage 1, on accept (in_valid & in_ready):
  - p1 <= a·b, 24 bits, unsigned.
  - e1 <= (a ≥ Q) | (b ≥ Q).
  - v1 <= 1.
- Stage 2 load:
  - out_data <= p1[23:12]·FOLD + p1[11:0]. Width 23; the maximum for legal inputs is 2478·909 + 4095 = 2256597 < 2^22, so there is no overflow.
  - out_err <= e1.
  - out_valid <= v1.
- Advance rules:
  - s2_load = !out_valid | out_ready.
  - s1_load = !v1 | s2_load.
  - in_ready = s1_load, combinational from out_ready and state. No combinational path from in_valid to in_ready.
- Stage data holds its value when the stage does not load. out_data and out_err stay stable while out_valid & !out_ready.
- Latency and throughput:
  - Latency is 2 cycles from accept to out_valid, with no stalls.
  - Throughput is 1 pair per cycle while out_ready = 1.
- Bubbles: if stage 1 is empty when stage 2 loads, out_valid drops to 0 and out_data holds its last value.
- Full pipeline: v1 = 1, out_valid = 1, out_ready = 0 gives in_ready = 0, and the block holds 2 items.
- Simultaneous accept and drain in the same cycle is legal and loses nothing.
- Out-of-range operands:
  - Still multiplied.
  - out_data is undefined modulo Q, but must not be X.
  - out_err = 1 travels with the item.
  - Illegal operands are at most 4095, so the product fits 24 bits and the fold fits 23 bits.
- Reset asserted mid-operation: all in-flight items are discarded immediately and the outputs go to their reset values.
- No ordering changes: results leave strictly in accept order.

Test Plan:
- Reset with in_valid = 1 held → out_valid = 0, out_data = 0 during reset; first accept in the cycle after release; out_valid in the 2nd cycle after accept.
- Stream (64,64), (1,3186), (0,5), (3186,3186) with out_ready = 1 → outputs on consecutive cycles: 909, 3186, 0, 2253210; each equals a·b mod 3187 after the reducer: 909, 3186, 0, 1.
- out_ready = 0 for 5 cycles during a 4-item stream → in_ready drops after 2 items are held; out_data stable; all 4 results delivered in order once out_ready = 1, with no loss or duplication.
- a = 3187, b = 2 → out_err = 1 with out_data = 6374 folded (1·909 + 2278 = 3187); the next legal pair gives out_err = 0.
- Assert rst_n low while 2 items are in flight → out_valid falls asynchronously within the same cycle; no stale item appears after release.
- Random 10k legal pairs with random out_ready, checked through barret_for_3187 → dout_r == (a·b) % 3187 for every item; count out == count in.

Source files
------------

// File: rtl/mod3187_mul_prefold_if.sv
// Handshake bundle for the mod-3187 multiply/prefold front end.
// The upstream side supplies operand pairs, and the downstream side consumes folded products.
interface mod3187_mul_prefold_if #(
  parameter int W     = 12,
  parameter int OUT_W = 23
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_err;

  // Producer / consumer view (testbench or surrounding logic)
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  // Block view
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/mod3187_mul_prefold.sv
// Two-stage modular-multiply front end for Q = 3187.
// Stage 1 forms the 24-bit product a*b. Stage 2 folds it once using 2^12 == 909 (mod Q).
// The folded value fits 23 bits and is congruent to a*b mod Q.
// Both stages are skid-free elastic registers: a stage loads when it is empty
// or when the stage after it is draining. The downstream ready therefore ripples
// combinationally back to in_ready, and in_valid never feeds in_ready.
module mod3187_mul_prefold #(
  parameter int Q     = 3187,
  parameter int W     = 12,
  parameter int FOLD  = 909,
  parameter int OUT_W = 23
) (
  input logic                   clk,
  input logic                   rst_n,
  mod3187_mul_prefold_if.slave  bus
);

  localparam int              PW     = 2 * W;
  localparam logic [W-1:0]    Q_W    = W'(Q);
  localparam logic [OUT_W-1:0] FOLD_W = OUT_W'(FOLD);

  // Stage 1: raw product plus operand-range flag
  logic             r_v1;
  logic [PW-1:0]    r_p1;
  logic             r_e1;

  // Stage 2: folded result presented to the consumer
  logic             r_out_valid;
  logic [OUT_W-1:0] r_out_data;
  logic             r_out_err;

  logic             w_s2_load;
  logic             w_s1_load;
  logic             w_accept;
  logic             w_err;
  logic [PW-1:0]    w_prod;
  logic [OUT_W-1:0] w_fold;

  assign w_s2_load = !r_out_valid || bus.out_ready;
  assign w_s1_load = !r_v1 || w_s2_load;
  assign w_accept  = bus.in_valid && w_s1_load;

  // Out-of-range operands are still multiplied. The flag travels with the item.
  assign w_err  = (bus.a >= Q_W) || (bus.b >= Q_W);
  assign w_prod = PW'(bus.a) * PW'(bus.b);

  // hi*909 + lo. The worst case with illegal operands (4094*909 + 4095) is still below 2^23.
  assign w_fold = OUT_W'(r_p1[PW-1:W]) * FOLD_W + OUT_W'(r_p1[W-1:0]);

  // Stage 1: capture the product on accept. Its data holds while the stage is idle or blocked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_p1 <= '0;
      r_e1 <= 1'b0;
    end else begin
      if (w_s1_load) begin
        r_v1 <= bus.in_valid;
      end
      if (w_accept) begin
        r_p1 <= w_prod;
        r_e1 <= w_err;
      end
    end
  end

  // Stage 2: fold on advance. Data only changes when a real item arrives, so bubbles keep the last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
    end else if (w_s2_load) begin
      r_out_valid <= r_v1;
      if (r_v1) begin
        r_out_data <= w_fold;
        r_out_err  <= r_e1;
      end
    end
  end

  assign bus.in_ready  = w_s1_load;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_err   = r_out_err;

endmodule
